chunked_seq_adder: RTL



---
 rtl/chunked_seq_adder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/chunked_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : ripple_carry_adder
//  Purpose  : Plain ripple-carry adder, one full adder per bit.
//  Ports    : a, b   - WIDTH-bit addends
//             c_in   - carry into bit 0
//             sum    - WIDTH-bit sum
//             c_out  - carry out of bit WIDTH-1
//  Revision : 1.0 - initial release
// ============================================================================
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_carry[WIDTH];

endmodule

// ============================================================================
//  Module   : chunked_seq_adder
//  Purpose  : Multi-cycle WIDTH-bit adder processing CHUNK bits per clock,
//             keeping the inter-chunk carry in a register. Valid/ready
//             handshake on operand and result sides; one operation in flight.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             in_valid / in_ready - operand handshake (a, b, c_in)
//             out_valid/out_ready - result handshake (sum, c_out, ovf)
//             sum   - (a + b + c_in) mod 2^WIDTH
//             c_out - unsigned carry out of bit WIDTH-1
//             ovf   - signed overflow (carry into MSB xor carry out)
//  Revision : 1.0 - initial release
// ============================================================================
module chunked_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_chunk_check
    $error("chunked_seq_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  localparam int c_num_chunks = WIDTH / CHUNK;
  localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_chunks - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_add  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [c_idx_w-1:0] r_idx;
  logic [WIDTH-1:0]   r_sum;
  logic               r_c_out;
  logic               r_ovf;

  logic [CHUNK-1:0]   w_chunk_sum;
  logic               w_chunk_cout;
  logic               w_msb_carry;
  logic               w_last;
  logic [31:0]        w_shamt;
  logic [WIDTH-1:0]   w_sum_mask;
  logic [WIDTH-1:0]   w_sum_next;

  // The captured operands shift right one chunk per ADD cycle, so the
  // active chunk is always in the low CHUNK bits.
  ripple_carry_adder #(
    .WIDTH (CHUNK)
  ) u_rca (
    .a     (r_a[CHUNK-1:0]),
    .b     (r_b[CHUNK-1:0]),
    .c_in  (r_carry),
    .sum   (w_chunk_sum),
    .c_out (w_chunk_cout)
  );

  // Carry into the top bit of the chunk, recovered from the sum bit.
  assign w_msb_carry = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
  assign w_last      = (r_idx == c_last_idx);

  // Only the bits of chunk r_idx are replaced; the rest of sum is untouched.
  assign w_shamt    = 32'(r_idx) * 32'(CHUNK);
  assign w_sum_mask = WIDTH'({CHUNK{1'b1}}) << w_shamt;
  assign w_sum_next = (r_sum & ~w_sum_mask) | (WIDTH'(w_chunk_sum) << w_shamt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (in_valid)  w_next_state = c_st_add;
      c_st_add:  if (w_last)    w_next_state = c_st_done;
      c_st_done: if (out_ready) w_next_state = c_st_idle;
      default:                  w_next_state = c_st_idle;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    in_ready  = (r_state == c_st_idle);
    out_valid = (r_state == c_st_done);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if ((r_state == c_st_idle) && in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= c_in;
        r_idx   <= '0;
      end else if (r_state == c_st_add) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_sum   <= w_sum_next;
        r_carry <= w_chunk_cout;
        r_idx   <= r_idx + c_idx_w'(1);
        if (w_last) begin
          r_c_out <= w_chunk_cout;
          r_ovf   <= w_msb_carry ^ w_chunk_cout;
        end
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire
